// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU op codes, RV32 encodings, FSM states.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_MUL = 5'd4;
    localparam logic [4:0] OP_DIV = 5'd8;
    localparam logic [4:0] OP_REM = 5'd9;
    localparam logic [4:0] OP_AND = 5'd10;
    localparam logic [4:0] OP_OR  = 5'd12;
    localparam logic [4:0] OP_XOR = 5'd13;
    localparam logic [4:0] OP_SLL = 5'd14;
    localparam logic [4:0] OP_SRL = 5'd15;
    localparam logic [4:0] OP_SRA = 5'd16;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ILL
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an RV32I/M arithmetic instruction into an ALU op code
// and, for immediate forms, the second operand.
module alu_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5
) (
    input  logic [31:0]       instr,
    output logic              legal,
    output logic [OP_W-1:0]   alu_op,
    output logic              use_imm,
    output logic [WIDTH-1:0]  imm
);

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] op;
    logic       unused_fields;

    assign opc = instr[6:0];
    assign f7  = instr[31:25];
    assign f3  = instr[14:12];
    assign unused_fields = ^{instr[19:15], instr[11:7]};
    assign alu_op = OP_W'(op);

    always_comb begin
        legal   = 1'b0;
        op      = 5'd0;
        use_imm = 1'b0;
        imm     = '0;
        case (opc)
            OPC_R: begin
                case (f7)
                    F7_BASE: begin
                        legal = 1'b1;
                        case (f3)
                            F3_ADD:  op = OP_ADD;
                            F3_SLL:  op = OP_SLL;
                            F3_XOR:  op = OP_XOR;
                            F3_SR:   op = OP_SRL;
                            F3_OR:   op = OP_OR;
                            F3_AND:  op = OP_AND;
                            default: legal = 1'b0;
                        endcase
                    end
                    F7_ALT: begin
                        legal = (f3 == F3_ADD) || (f3 == F3_SR);
                        op    = (f3 == F3_SR) ? OP_SRA : OP_SUB;
                    end
                    F7_MULDIV: begin
                        legal = 1'b1;
                        case (f3)
                            F3_ADD:  op = OP_MUL;
                            F3_XOR:  op = OP_DIV;
                            F3_OR:   op = OP_REM;
                            default: legal = 1'b0;
                        endcase
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_I: begin
                use_imm = 1'b1;
                // Shifts take a zero-extended shamt; everything else a sign-extended imm12.
                if (f3 == F3_SLL || f3 == F3_SR)
                    imm = {{(WIDTH-5){1'b0}}, instr[24:20]};
                else
                    imm = {{(WIDTH-12){instr[31]}}, instr[31:20]};
                case (f3)
                    F3_ADD: begin legal = 1'b1; op = OP_ADD; end
                    F3_XOR: begin legal = 1'b1; op = OP_XOR; end
                    F3_OR:  begin legal = 1'b1; op = OP_OR;  end
                    F3_AND: begin legal = 1'b1; op = OP_AND; end
                    F3_SLL: begin legal = (f7 == F7_BASE); op = OP_SLL; end
                    F3_SR: begin
                        legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        op    = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one decoded op, pulses the ALU once, waits (bounded)
// for its result and hands it to writeback over valid/ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OP_W    = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    output logic              alu_en,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_valid,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [WIDTH-1:0]  wb_data,
    output logic              illegal,
    output logic              timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_d;
    logic              legal, use_imm, accept, cnt_hit;
    logic [OP_W-1:0]   dec_op;
    logic [WIDTH-1:0]  imm;
    logic [CNT_W-1:0]  cnt;

    alu_decode #(.WIDTH(WIDTH), .OP_W(OP_W)) u_decode (
        .instr   (instr),
        .legal   (legal),
        .alu_op  (dec_op),
        .use_imm (use_imm),
        .imm     (imm)
    );

    assign in_ready = (state == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign cnt_hit  = (cnt == CNT_W'(TIMEOUT));
    assign alu_en   = (state == S_ISSUE);
    assign wb_valid = (state == S_RESP);
    assign illegal  = (state == S_ILL);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (accept) state_d = legal ? S_ISSUE : S_ILL;
            S_ISSUE: state_d = S_WAIT;
            // A result arriving on the final count still wins over the abort.
            S_WAIT: begin
                if (alu_valid)    state_d = S_RESP;
                else if (cnt_hit) state_d = S_IDLE;
            end
            S_RESP:  if (wb_ready) state_d = S_IDLE;
            S_ILL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= (state == S_WAIT) && !alu_valid && cnt_hit;
            if (accept && legal) begin
                alu_a  <= rs1_data;
                alu_b  <= use_imm ? imm : rs2_data;
                alu_op <= dec_op;
                wb_rd  <= instr[11:7];
            end
            if (state == S_ISSUE)
                cnt <= '0;
            else if (state == S_WAIT && !alu_valid && !cnt_hit)
                cnt <= cnt + 1'b1;
            if (state == S_WAIT && alu_valid)
                wb_data <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed ops, an ALU stub, and monitors that
// check every ALU issue and every writeback handshake against queued expectations.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst, in_valid, wb_ready;
    logic        in_ready, alu_en, wb_valid, illegal, timeout;
    logic [31:0] instr, rs1_data, rs2_data, alu_a, alu_b, wb_data;
    logic [31:0] alu_result = '0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_op, wb_rd;

    typedef struct packed { logic [4:0] op; logic [31:0] a; logic [31:0] b; } iss_t;
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;

    iss_t iss_q[$];
    wb_t  wb_q[$];
    iss_t iss_e;
    wb_t  wb_e;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, iv_cyc = 0;
    int n_en = 0, n_ill = 0, n_to = 0;
    logic        stub_on = 1'b1, poke = 1'b0, fire_q = 1'b0;
    logic [31:0] res_q = '0;

    alu_issue #(.WIDTH(32), .OP_W(5), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_valid(alu_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd1:  return a + b;
            5'd3:  return a - b;
            5'd4:  return a * b;
            5'd8:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd9:  return (b == 0) ? a : a % b;
            5'd10: return a & b;
            5'd12: return a | b;
            5'd13: return a ^ b;
            5'd14: return a << b[4:0];
            5'd15: return a >> b[4:0];
            5'd16: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'hBAD0_BAD0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ALU stub: sees alu_en in the ISSUE cycle, answers for one cycle after the next edge.
    always @(posedge clk) begin
        #1;
        alu_valid  = fire_q;
        alu_result = res_q;
    end

    always @(negedge clk) begin
        if (alu_en)  n_en++;
        if (illegal) n_ill++;
        if (timeout) n_to++;
        if (alu_en) begin
            if (iss_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL alu_en_unexpected: got 1 expected 0");
            end else begin
                iss_e = iss_q.pop_front();
                chk("alu_op", 32'(alu_op), 32'(iss_e.op));
                chk("alu_a", alu_a, iss_e.a);
                chk("alu_b", alu_b, iss_e.b);
            end
        end
        fire_q = (alu_en && stub_on) || poke;
        res_q  = poke ? 32'hDEAD_BEEF : alu_model(alu_op, alu_a, alu_b);
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wb_valid_unexpected: got 1 expected 0");
            end else if (wb_ready) begin
                wb_e = wb_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(wb_e.rd));
                chk("wb_data", wb_data, wb_e.data);
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 60) begin @(negedge clk); k++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_in_ready: got 0 expected 1");
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        iv_cyc   = cyc;
        in_valid = 1'b1;
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [31:0] eb, input logic [31:0] data);
        iss_q.push_back('{op, a, eb});
        wb_q.push_back('{ins[11:7], data});
        send(ins, a, b);
    endtask

    task automatic drain();
        int k = 0;
        while (wb_q.size() != 0 && k < 60) begin @(negedge clk); k++; end
        if (wb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending expected 0", wb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic ill_op(input logic [31:0] ins);
        int i0, e0;
        i0 = n_ill; e0 = n_en;
        send(ins, 32'd1, 32'd2);
        @(negedge clk);
        chk("illegal_pulse", 32'(illegal), 32'd1);
        @(negedge clk);
        chk("ill_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("ill_width", 32'(n_ill - i0), 32'd1);
        chk("ill_no_alu_en", 32'(n_en - e0), 32'd0);
    endtask

    initial begin
        int k, d, e0, t0;
        rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_flags", 32'({alu_en, wb_valid, illegal, timeout}), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_wb", {wb_rd, wb_data[26:0]} | wb_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ADD with latency check
        do_op(rtype(7'b0000000, 3'b000, 5'd3), 32'd5, 32'd7, 5'd1, 32'd7, 32'd12);
        k = 0;
        while (!wb_valid && k < 20) begin @(negedge clk); k++; end
        chk("latency", 32'(cyc - iv_cyc), 32'd3);
        drain();

        do_op(rtype(7'b0100000, 3'b000, 5'd4), 32'd3, 32'd5, 5'd3, 32'd5, 32'hFFFF_FFFE);
        do_op(itype(12'hFFF, 3'b000, 5'd5), 32'h10, 32'h55, 5'd1, 32'hFFFF_FFFF, 32'hF);
        do_op(itype({7'b0100000, 5'd4}, 3'b101, 5'd6), 32'h8000_0000, 32'h1234, 5'd16, 32'd4, 32'hF800_0000);
        do_op(rtype(7'b0000001, 3'b000, 5'd7), 32'd6, 32'd7, 5'd4, 32'd7, 32'd42);
        do_op(rtype(7'b0000001, 3'b100, 5'd8), 32'd100, 32'd7, 5'd8, 32'd7, 32'd14);
        do_op(rtype(7'b0000001, 3'b110, 5'd9), 32'd100, 32'd7, 5'd9, 32'd7, 32'd2);
        do_op(rtype(7'b0000000, 3'b100, 5'd10), 32'hF0F0, 32'hFF00, 5'd13, 32'hFF00, 32'h0FF0);
        do_op(rtype(7'b0000000, 3'b001, 5'd11), 32'd1, 32'd31, 5'd14, 32'd31, 32'h8000_0000);
        do_op(rtype(7'b0000000, 3'b101, 5'd12), 32'h8000_0000, 32'd4, 5'd15, 32'd4, 32'h0800_0000);
        do_op(rtype(7'b0000000, 3'b110, 5'd13), 32'hF0, 32'h0F, 5'd12, 32'h0F, 32'hFF);
        do_op(rtype(7'b0000000, 3'b111, 5'd14), 32'hFF, 32'h3C, 5'd10, 32'h3C, 32'h3C);
        do_op(itype(12'h0F0, 3'b111, 5'd15), 32'hFFFF, 32'h1, 5'd10, 32'hF0, 32'hF0);
        do_op(itype({7'b0000000, 5'd8}, 3'b001, 5'd16), 32'd1, 32'h77, 5'd14, 32'd8, 32'h100);
        do_op(rtype(7'b0000000, 3'b000, 5'd0), 32'd1, 32'd1, 5'd1, 32'd1, 32'd2);
        drain();

        // Unsupported encodings
        ill_op(rtype(7'b0000000, 3'b010, 5'd3));   // SLT
        ill_op(rtype(7'b0000001, 3'b001, 5'd3));   // MULH
        ill_op(rtype(7'b0000001, 3'b101, 5'd3));   // DIVU
        ill_op(itype(12'h005, 3'b010, 5'd3));      // SLTI
        ill_op(32'h0000_10B7);                     // LUI

        // Stray alu_valid while idle must be ignored
        @(posedge clk); #1 poke = 1'b1;
        @(posedge clk); #1 poke = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_alu_valid_idle", 32'(in_ready), 32'd1);

        // Writeback backpressure
        @(posedge clk); #1 wb_ready = 1'b0;
        e0 = n_en;
        do_op(rtype(7'b0000000, 3'b000, 5'd17), 32'd2, 32'd3, 5'd1, 32'd3, 32'd5);
        k = 0;
        while (!wb_valid && k < 20) begin @(negedge clk); k++; end
        in_valid = 1'b1; instr = rtype(7'b0000000, 3'b000, 5'd18); rs1_data = 32'd9; rs2_data = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_wb_valid", 32'(wb_valid), 32'd1);
            chk("bp_wb_data", wb_data, 32'd5);
            chk("bp_wb_rd", 32'(wb_rd), 32'd17);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0; wb_ready = 1'b1;
        drain();
        chk("bp_single_issue", 32'(n_en - e0), 32'd1);

        // ALU never answers
        stub_on = 1'b0;
        t0 = n_to;
        iss_q.push_back('{5'd1, 32'd1, 32'd1});
        send(rtype(7'b0000000, 3'b000, 5'd19), 32'd1, 32'd1);
        k = 0;
        while (!timeout && k < 40) begin @(negedge clk); k++; end
        d = cyc - iv_cyc;
        n_cmp++;
        if (d < 16 || d > 18) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d expected 16..18", d);
        end
        @(negedge clk);
        chk("to_width", 32'(n_to - t0), 32'd1);
        chk("to_in_ready", 32'(in_ready), 32'd1);

        // Reset while waiting
        iss_q.push_back('{5'd1, 32'd1, 32'd1});
        send(rtype(7'b0000000, 3'b000, 5'd20), 32'd1, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_flags", 32'({in_ready, alu_en, wb_valid, illegal, timeout}), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0; stub_on = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_no_timeout", 32'(n_to - t0), 32'd1);

        do_op(rtype(7'b0000000, 3'b000, 5'd21), 32'd40, 32'd2, 5'd1, 32'd2, 32'd42);
        drain();
        chk("iss_q_empty", 32'(iss_q.size()), 32'd0);
        chk("wb_q_empty", 32'(wb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
